// File: rtl/icache_pkg.sv
// Shared widths, constants and FSM encoding for the instruction cache.
package icache_pkg;

    localparam int ADDR     = 32;
    localparam int INSTRLEN = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [31:0] NULL32 = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits (reset), tag and data (not reset).
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = ADDR - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [INSTRLEN-1:0]   rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [INSTRLEN-1:0]   wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [INSTRLEN-1:0] words [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= TRUE;
        end
    end

    // Payload arrays are left unreset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

endmodule

// File: rtl/icache.sv
// Single-word-line direct-mapped instruction cache with IDLE/MISS/DONE control.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                icache_enable,
    input  logic [ADDR-1:0]     pc_to_fetch,
    output logic [INSTRLEN-1:0] instr_fetched,
    output logic                icache_success,
    input  logic                jump_wrong,
    output logic                mem_enable,
    output logic [ADDR-1:0]     mem_addr,
    input  logic [INSTRLEN-1:0] mem_data,
    input  logic                mem_success
);

    localparam int TAG_BITS = ADDR - INDEX_BITS - 2;

    state_t state, state_n;

    logic                  success_n;
    logic                  mem_enable_n;
    logic [ADDR-1:0]       mem_addr_n;
    logic [INSTRLEN-1:0]   instr_n;
    logic                  wr_en;
    logic                  rd_valid;
    logic                  hit;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INSTRLEN-1:0]   rd_data;
    logic [INDEX_BITS-1:0] rd_index;
    logic [TAG_BITS-1:0]   pc_tag;

    assign rd_index = pc_to_fetch[INDEX_BITS+1:2];
    assign pc_tag   = pc_to_fetch[ADDR-1:INDEX_BITS+2];
    assign hit      = rd_valid && (rd_tag == pc_tag);

    // mem_addr doubles as the latched miss address for the refill write.
    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (mem_addr[INDEX_BITS+1:2]),
        .wr_tag   (mem_addr[ADDR-1:INDEX_BITS+2]),
        .wr_data  (mem_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            icache_success <= FALSE;
            mem_enable     <= FALSE;
            mem_addr       <= NULL32;
            instr_fetched  <= NULL32;
        end else if (rdy) begin
            state          <= state_n;
            icache_success <= success_n;
            mem_enable     <= mem_enable_n;
            mem_addr       <= mem_addr_n;
            instr_fetched  <= instr_n;
        end
    end

    always_comb begin
        state_n      = state;
        success_n    = FALSE;
        mem_enable_n = mem_enable;
        mem_addr_n   = mem_addr;
        instr_n      = instr_fetched;
        wr_en        = FALSE;
        if (rdy) begin
            if (jump_wrong) begin
                // A refill landing on the flush cycle is kept, but not reported.
                wr_en        = (state == MISS) && mem_success;
                state_n      = IDLE;
                mem_enable_n = FALSE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (icache_enable && hit) begin
                            instr_n   = rd_data;
                            success_n = TRUE;
                            state_n   = DONE;
                        end else if (icache_enable) begin
                            mem_enable_n = TRUE;
                            mem_addr_n   = pc_to_fetch & ~ADDR'(3);
                            state_n      = MISS;
                        end
                    end
                    MISS: begin
                        if (mem_success) begin
                            wr_en        = TRUE;
                            instr_n      = mem_data;
                            success_n    = TRUE;
                            mem_enable_n = FALSE;
                            state_n      = DONE;
                        end
                    end
                    DONE: begin
                        state_n = IDLE;
                    end
                    default: begin
                        state_n      = IDLE;
                        mem_enable_n = FALSE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a transaction-level model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        icache_enable = 1'b0;
    logic [31:0] pc_to_fetch = 32'h0;
    logic [31:0] instr_fetched;
    logic        icache_success;
    logic        jump_wrong = 1'b0;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic        mem_success = 1'b0;

    int checks = 0;
    int errors = 0;

    icache #(.INDEX_BITS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .icache_enable  (icache_enable),
        .pc_to_fetch    (pc_to_fetch),
        .instr_fetched  (instr_fetched),
        .icache_success (icache_success),
        .jump_wrong     (jump_wrong),
        .mem_enable     (mem_enable),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_success    (mem_success)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: cache holds the full word address per index.
    bit          mv [256];
    logic [29:0] mw [256];
    logic [31:0] md [256];
    bit          pend;
    bit          cool;
    logic        e_succ;
    logic        e_men;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    int          k;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (mv[i]) mv[i] = 1'b0;
            pend    = 1'b0;
            cool    = 1'b0;
            e_succ  = 1'b0;
            e_men   = 1'b0;
            e_addr  = 32'h0;
            e_instr = 32'h0;
        end else if (rdy) begin
            e_succ = 1'b0;
            if (pend && mem_success) begin
                k     = int'(e_addr[9:2]);
                mv[k] = 1'b1;
                mw[k] = e_addr[31:2];
                md[k] = mem_data;
            end
            if (jump_wrong) begin
                pend  = 1'b0;
                cool  = 1'b0;
                e_men = 1'b0;
            end else if (pend) begin
                if (mem_success) begin
                    e_instr = mem_data;
                    e_succ  = 1'b1;
                    e_men   = 1'b0;
                    pend    = 1'b0;
                    cool    = 1'b1;
                end
            end else if (cool) begin
                cool = 1'b0;
            end else if (icache_enable) begin
                k = int'(pc_to_fetch[9:2]);
                if (mv[k] && mw[k] == pc_to_fetch[31:2]) begin
                    e_instr = md[k];
                    e_succ  = 1'b1;
                    cool    = 1'b1;
                end else begin
                    pend   = 1'b1;
                    e_men  = 1'b1;
                    e_addr = {pc_to_fetch[31:2], 2'b00};
                end
            end
        end
        #1;
        check("model_success", icache_success, e_succ);
        check("model_mem_enable", mem_enable, e_men);
        if (e_men) check("model_mem_addr", mem_addr, e_addr);
        if (e_succ) check("model_instr", instr_fetched, e_instr);
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom % 4) << 10;
        p = p | (($urandom % 8) << 2) | ($urandom % 4);
        return p;
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_success", icache_success, 0);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr", instr_fetched, 0);
        rst_n = 1'b1;
        rdy   = 1'b1;

        // cold miss and refill of pc 0
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0;
        tick();
        check("cold_mem_enable", mem_enable, 1);
        check("cold_mem_addr", mem_addr, 32'h0);
        mem_success = 1'b1;
        mem_data    = 32'h0000_0513;
        tick();
        mem_success   = 1'b0;
        icache_enable = 1'b0;
        check("refill_success", icache_success, 1);
        check("refill_instr", instr_fetched, 32'h0000_0513);
        tick();
        check("done_no_repeat", icache_success, 0);

        // warm hit
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0;
        tick();
        check("hit_success", icache_success, 1);
        check("hit_instr", instr_fetched, 32'h0000_0513);
        check("hit_no_mem", mem_enable, 0);
        icache_enable = 1'b0;
        tick();

        // conflicting line evicts pc 0
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h400;
        tick();
        check("conflict_miss", mem_enable, 1);
        check("conflict_addr", mem_addr, 32'h400);
        mem_success = 1'b1;
        mem_data    = 32'h00a0_0093;
        tick();
        mem_success   = 1'b0;
        icache_enable = 1'b0;
        check("conflict_instr", instr_fetched, 32'h00a0_0093);
        tick();
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0;
        tick();
        check("evicted_remiss", mem_enable, 1);
        mem_success = 1'b1;
        mem_data    = 32'h0000_0513;
        tick();
        mem_success   = 1'b0;
        icache_enable = 1'b0;
        tick();

        // flush during outstanding miss
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h10;
        tick();
        check("flush_pre_miss", mem_enable, 1);
        jump_wrong    = 1'b1;
        icache_enable = 1'b0;
        tick();
        jump_wrong = 1'b0;
        check("flush_mem_enable", mem_enable, 0);
        check("flush_success", icache_success, 0);
        mem_success = 1'b1;
        mem_data    = 32'hdead_beef;
        tick();
        mem_success = 1'b0;
        check("late_fill_success", icache_success, 0);
        check("late_fill_mem_en", mem_enable, 0);
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h10;
        tick();
        check("late_fill_ignored", mem_enable, 1);
        jump_wrong    = 1'b1;
        icache_enable = 1'b0;
        tick();
        jump_wrong = 1'b0;

        // flush coinciding with refill still writes the line
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h20;
        tick();
        check("jwfill_miss", mem_enable, 1);
        jump_wrong    = 1'b1;
        mem_success   = 1'b1;
        mem_data      = 32'h0010_0093;
        icache_enable = 1'b0;
        tick();
        jump_wrong  = 1'b0;
        mem_success = 1'b0;
        check("jwfill_no_success", icache_success, 0);
        check("jwfill_mem_en", mem_enable, 0);
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h20;
        tick();
        check("jwfill_hit", icache_success, 1);
        check("jwfill_hit_instr", instr_fetched, 32'h0010_0093);
        check("jwfill_hit_no_mem", mem_enable, 0);

        // enable held high: pulses alternate
        for (int i = 0; i < 6; i++) begin
            tick();
            check("alternate", icache_success, 32'(i % 2));
        end
        rdy = 1'b0;
        tick();
        check("stall_hold_1", icache_success, 1);
        tick();
        check("stall_hold_2", icache_success, 1);
        rdy = 1'b1;
        tick();
        check("stall_release", icache_success, 0);
        icache_enable = 1'b0;
        tick();

        // asynchronous reset mid-miss
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h30;
        tick();
        check("rstmiss_pre", mem_enable, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", mem_enable, 0);
        check("async_rst_addr", mem_addr, 0);
        tick();
        rst_n       = 1'b1;
        pc_to_fetch = 32'h20;
        tick();
        check("rst_clears_valid", mem_enable, 1);
        check("rst_clears_addr", mem_addr, 32'h20);
        jump_wrong    = 1'b1;
        icache_enable = 1'b0;
        tick();
        jump_wrong = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            rdy        = ($urandom % 8) != 0;
            jump_wrong = ($urandom % 25) == 0;
            if (icache_success || !icache_enable) begin
                icache_enable = ($urandom % 4) != 0;
                pc_to_fetch   = rand_pc();
            end else if ($urandom % 30 == 0) begin
                icache_enable = 1'b0;
            end
            mem_data = $urandom;
            if (mem_enable) mem_success = ($urandom % 3) == 0;
            else mem_success = ($urandom % 30) == 0;
        end
        icache_enable = 1'b0;
        mem_success   = 1'b0;
        jump_wrong    = 1'b0;
        rdy           = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
